// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared defaults and op-mode encoding for the pipelined add/sub block
package addsub_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEG   = 8;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/cla_segment.sv
// rtl/cla_segment.sv - SEG-bit generate/propagate carry-lookahead adder slice
module cla_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb
);

    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;
    logic           prod;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is the flat sum of products g[j]&p[i..j+1], plus ci&p[i..0].
    always_comb begin
        c    = '0;
        prod = 1'b0;
        c[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            c[i+1] = g[i];
            prod   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (prod & g[j]);
                prod   = prod & p[j];
            end
            c[i+1] = c[i+1] | (prod & ci);
        end
    end

    assign s     = p ^ c[SEG-1:0];
    assign co    = c[SEG];
    assign c_msb = c[SEG-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - NSEG-stage pipelined CLA adder/subtractor; ADDSUB_SAT_EN enables saturation
module pipelined_cla_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NSEG = WIDTH / SEG;

    op_e              op;
    logic             advance;

    // Stage k inputs (from ports for k = 0, else from stage k-1 registers).
    logic [WIDTH-1:0] x_d   [NSEG];
    logic [WIDTH-1:0] b_d   [NSEG];
    logic             c_d   [NSEG];
    logic             v_d   [NSEG];
    logic [WIDTH-1:0] x_n   [NSEG];

    // x_q holds resolved sum bits below the current segment and raw A bits above it.
    logic [WIDTH-1:0] x_q   [NSEG];
    logic [WIDTH-1:0] b_q   [NSEG];
    logic             c_q   [NSEG];
    logic             v_q   [NSEG];
    logic             ov_q;

    logic [SEG-1:0]   seg_s [NSEG];
    logic             seg_co[NSEG];
    logic             seg_cm[NSEG];

    assign op        = op_e'(op_sub);
    assign advance   = ~v_q[NSEG-1] | out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[NSEG-1];
    assign sum       = x_q[NSEG-1];
    assign cout      = c_q[NSEG-1];
    assign overflow  = ov_q;

    // Subtract folds into add: invert B and the borrow once, at entry.
    always_comb begin
        x_d[0] = a;
        b_d[0] = (op == OP_SUB) ? ~b : b;
        c_d[0] = (op == OP_SUB) ? ~cin : cin;
        v_d[0] = in_valid;
        for (int k = 1; k < NSEG; k++) begin
            x_d[k] = x_q[k-1];
            b_d[k] = b_q[k-1];
            c_d[k] = c_q[k-1];
            v_d[k] = v_q[k-1];
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        cla_segment #(
            .SEG(SEG)
        ) u_seg (
            .a    (x_d[k][k*SEG +: SEG]),
            .b    (b_d[k][k*SEG +: SEG]),
            .ci   (c_d[k]),
            .s    (seg_s[k]),
            .co   (seg_co[k]),
            .c_msb(seg_cm[k])
        );
    end

    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            x_n[k]                = x_d[k];
            x_n[k][k*SEG +: SEG]  = seg_s[k];
        end
`ifdef ADDSUB_SAT_EN
        // Overflow implies both operands share A's sign, so A's MSB picks the rail.
        if (seg_cm[NSEG-1] ^ seg_co[NSEG-1]) begin
            x_n[NSEG-1] = {x_d[NSEG-1][WIDTH-1], {(WIDTH-1){~x_d[NSEG-1][WIDTH-1]}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSEG; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                x_q[k] <= '0;
                b_q[k] <= '0;
            end
            ov_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < NSEG; k++) begin
                v_q[k] <= v_d[k];
                c_q[k] <= seg_co[k];
                x_q[k] <= x_n[k];
                b_q[k] <= b_d[k];
            end
            ov_q <= seg_cm[NSEG-1] ^ seg_co[NSEG-1];
        end
    end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb/tb_pipelined_cla_addsub.sv - self-checking bench for pipelined_cla_addsub
module tb_pipelined_cla_addsub;

    localparam int WIDTH = 32;
    localparam int SEG   = 8;
    localparam int NSEG  = WIDTH / SEG;

`ifdef ADDSUB_SAT_EN
    localparam logic [31:0] OVF_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] OVF_NEG = 32'h8000_0000;
`else
    localparam logic [31:0] OVF_POS = 32'h8000_0000;
    localparam logic [31:0] OVF_NEG = 32'h7FFF_FFFF;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              cin;
    logic              op_sub;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  sum;
    logic              cout;
    logic              overflow;

    pipelined_cla_addsub #(
        .WIDTH(WIDTH),
        .SEG  (SEG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .op_sub   (op_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ov;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          n_acc    = 0;
    int          n_out    = 0;
    bit          dir_valid;
    exp_t        dir_exp;
    bit          prev_stall;
    logic [31:0] prev_sum;
    logic        prev_cout;
    logic        prev_ov;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: signed arithmetic on wide integers, overflow as range escape.
    function automatic exp_t model(input logic [31:0] ai, input logic [31:0] bi,
                                   input logic ci, input logic op);
        exp_t        e;
        logic [32:0] ext;
        longint      sv;
        if (op) begin
            ext = {1'b0, ai} + {1'b0, ~bi} + {32'd0, ~ci};
            sv  = longint'($signed(ai)) - longint'($signed(bi)) - longint'(ci);
        end else begin
            ext = {1'b0, ai} + {1'b0, bi} + {32'd0, ci};
            sv  = longint'($signed(ai)) + longint'($signed(bi)) + longint'(ci);
        end
        e.sum  = ext[31:0];
        e.cout = ext[32];
        e.ov   = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
`ifdef ADDSUB_SAT_EN
        if (e.ov) e.sum = (sv > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        e.acc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] corner [4];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'h7FFF_FFFF;
        if ($urandom_range(7, 0) == 0) return corner[$urandom_range(3, 0)];
        return $urandom;
    endfunction

    // Observe handshakes at the falling edge, then advance past the next rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_sum", sum, prev_sum);
                check("hold_cout", cout, prev_cout);
                check("hold_ov", overflow, prev_ov);
            end
            if (out_valid && !out_ready) check("bp_in_ready", in_ready, 0);
            prev_stall = out_valid && !out_ready;
            prev_sum   = sum;
            prev_cout  = cout;
            prev_ov    = overflow;
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("sum", sum, e.sum);
                    check("cout", cout, e.cout);
                    check("overflow", overflow, e.ov);
                    if (e.lat) check("latency", cyc - e.acc, NSEG);
                end
            end
            if (in_valid && in_ready) begin
                if (dir_valid) e = dir_exp;
                else           e = model(a, b, cin, op_sub);
                e.acc = cyc;
                q.push_back(e);
                n_acc++;
            end
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < n && q.size() > 0; i++) step();
        check("drain_empty", q.size(), 0);
    endtask

    task automatic send_dir(input logic [31:0] ai, input logic [31:0] bi, input logic ci,
                            input logic op, input logic [31:0] es, input logic ec, input logic eo);
        a            = ai;
        b            = bi;
        cin          = ci;
        op_sub       = op;
        in_valid     = 1'b1;
        out_ready    = 1'b1;
        dir_valid    = 1'b1;
        dir_exp.sum  = es;
        dir_exp.cout = ec;
        dir_exp.ov   = eo;
        dir_exp.lat  = 1'b1;
        dir_exp.acc  = 0;
        step();
        in_valid  = 1'b0;
        dir_valid = 1'b0;
        drain(20);
    endtask

    initial begin
        int base;
        int base_out;
        int guard;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        op_sub     = 1'b0;
        out_ready  = 1'b1;
        dir_valid  = 1'b0;
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        step();

        send_dir(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        send_dir(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, OVF_POS,       1'b0, 1'b1);
        send_dir(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send_dir(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, OVF_NEG,       1'b1, 1'b1);
        send_dir(32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
        send_dir(32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0);

        base     = n_acc;
        base_out = n_out;
        for (int i = 0; i < 40 && (n_acc - base) < 8; i++) begin
            out_ready = !(i >= 5 && i <= 7);
            in_valid  = 1'b1;
            a         = pick();
            b         = pick();
            cin       = 1'($urandom_range(1, 0));
            op_sub    = 1'($urandom_range(1, 0));
            step();
        end
        drain(20);
        check("bp_accepted", n_acc - base, 8);
        check("bp_emitted", n_out - base_out, 8);

        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = pick();
            b        = pick();
            cin      = 1'($urandom_range(1, 0));
            op_sub   = 1'($urandom_range(1, 0));
            step();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        q.delete();
        step();
        step();
        rst_n = 1'b1;
        repeat (8) begin
            step();
            check("flush_out_valid", out_valid, 0);
        end

        base  = n_acc;
        guard = 0;
        while ((n_acc - base) < 10000 && guard < 60000) begin
            in_valid  = ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(3, 0) != 0);
            a         = pick();
            b         = pick();
            cin       = 1'($urandom_range(1, 0));
            op_sub    = 1'($urandom_range(1, 0));
            step();
            guard++;
        end
        check("rand_beats", n_acc - base, 10000);
        drain(50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
